// File: rtl/mem_pkg.sv
// Shared types and helpers for the data memory: FSM state, clog2 and the request address check.
package mem_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam int CHK_ADDR_W = 64;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        while ((1 << res) < value) begin
            res = res + 1;
        end
        return res;
    endfunction

    // Flags misaligned offset bits and any address bit above the word-index field.
    function automatic logic addr_err(input logic [CHK_ADDR_W-1:0] addr,
                                      input int off_w,
                                      input int idx_w);
        logic err;
        err = 1'b0;
        for (int i = 0; i < CHK_ADDR_W; i++) begin
            if (addr[i] && ((i < off_w) || (i >= off_w + idx_w))) begin
                err = 1'b1;
            end
        end
        return err;
    endfunction

endpackage

// File: rtl/data_ram_array.sv
// Word storage with byte-lane writes and a registered read port; no reset so it maps onto block RAM.
module data_ram_array
    import mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024
) (
    input  logic                     clk,
    input  logic [clog2(DEPTH)-1:0]  i_addr,
    input  logic                     i_we,
    input  logic [DATA_W/8-1:0]      i_be,
    input  logic [DATA_W-1:0]        i_wdata,
    input  logic                     i_re,
    output logic [DATA_W-1:0]        o_rdata
);

    localparam int BYTES = DATA_W / 8;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (i_be[b]) begin
                    r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
        // Read-before-write: a load sees the word as it stood before this edge.
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_ram.sv
// Single-port data memory for the load/store path: handshake, byte strobes, address checking
// and a post-reset clear sequencer in front of the word array.
module data_ram
    import mem_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int DEPTH          = 1024,
    parameter int ADDR_W         = 32,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                busy
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = clog2(BYTES);
    localparam int IDX_W = clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

    state_t             r_state;
    logic [IDX_W-1:0]   r_clr_idx;
    logic               r_rsp_valid;
    logic               r_rsp_err;
    logic               r_rsp_load;

    logic               w_run;
    logic               w_req_ready;
    logic               w_accept;
    logic               w_err;
    logic [IDX_W-1:0]   w_req_idx;

    logic [IDX_W-1:0]   w_arr_addr;
    logic               w_arr_we;
    logic [BYTES-1:0]   w_arr_be;
    logic [DATA_W-1:0]  w_arr_wdata;
    logic               w_arr_re;
    logic [DATA_W-1:0]  w_arr_rdata;

    assign w_run       = (r_state == ST_RUN);
    // Ready is held low while clr is asserted so nothing is accepted during reset.
    assign w_req_ready = w_run && !clr && (!r_rsp_valid || rsp_ready);
    assign w_accept    = req_valid && w_req_ready;
    assign w_err       = addr_err(CHK_ADDR_W'(req_addr), OFF_W, IDX_W);
    assign w_req_idx   = req_addr[OFF_W +: IDX_W];

    always_comb begin
        w_arr_addr  = w_req_idx;
        w_arr_we    = 1'b0;
        w_arr_be    = req_be;
        w_arr_wdata = req_wdata;
        w_arr_re    = 1'b0;
        if (!w_run) begin
            w_arr_addr  = r_clr_idx;
            w_arr_we    = 1'b1;
            w_arr_be    = '1;
            w_arr_wdata = '0;
        end else begin
            w_arr_we = w_accept && req_write && !w_err;
            w_arr_re = w_accept && !req_write && !w_err;
        end
    end

    data_ram_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk     (clk),
        .i_addr  (w_arr_addr),
        .i_we    (w_arr_we),
        .i_be    (w_arr_be),
        .i_wdata (w_arr_wdata),
        .i_re    (w_arr_re),
        .o_rdata (w_arr_rdata)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state     <= RESET_STATE;
            r_clr_idx   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_load  <= 1'b0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_clr_idx <= r_clr_idx + 1'b1;
                    if (r_clr_idx == LAST_IDX) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_accept) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= w_err;
                        r_rsp_load  <= !req_write && !w_err;
                    end else if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: r_state <= RESET_STATE;
            endcase
        end
    end

    // Array read data is only presented for a successful load; stores and errors return zero.
    assign rsp_rdata = r_rsp_load ? w_arr_rdata : '0;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign req_ready = w_req_ready;
    assign busy      = !w_run;

endmodule

// File: tb/tb_data_ram.sv
// Directed bench for data_ram: vector table plus hand-written clear, back-pressure and reset sequences.
module tb_data_ram;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 32;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr  = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be    = '0;
    logic        rsp_ready = 1'b1;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [12];

    data_ram #(
        .DATA_W         (DATA_W),
        .DEPTH          (DEPTH),
        .ADDR_W         (ADDR_W),
        .CLEAR_ON_RESET (1)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_rsp(input string name, input logic [31:0] exp_rdata, input logic exp_err);
        chk({name, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({name, "_rdata"}, rsp_rdata, exp_rdata);
        chk({name, "_err"}, 32'(rsp_err), 32'(exp_err));
    endtask

    // Called on a falling edge; returns on the falling edge after the accepting rising edge.
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
        #1;
        while (!req_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("issue_timeout", 32'(req_ready), 32'd1);
        end else begin
            @(negedge clk);
        end
        req_valid = 1'b0;
    endtask

    // Called on the falling edge where clr was just released.
    task automatic count_busy(input string name);
        int c;
        c = 0;
        while (busy && c < 3000) begin
            c++;
            @(negedge clk);
        end
        chk(name, 32'(c), 32'(DEPTH));
        chk({name, "_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{1'b1, 32'h20,  32'h11223344, 4'b1111, 32'h0,        1'b0};
        vecs[1]  = '{1'b1, 32'h20,  32'hAABBCCDD, 4'b0101, 32'h0,        1'b0};
        vecs[2]  = '{1'b0, 32'h20,  32'h0,        4'b0000, 32'h11BB33DD, 1'b0};
        vecs[3]  = '{1'b0, 32'h22,  32'h0,        4'b0000, 32'h0,        1'b1};
        vecs[4]  = '{1'b0, 32'h1000,32'h0,        4'b0000, 32'h0,        1'b1};
        vecs[5]  = '{1'b1, 32'h22,  32'hFFFFFFFF, 4'b1111, 32'h0,        1'b1};
        vecs[6]  = '{1'b0, 32'h20,  32'h0,        4'b0000, 32'h11BB33DD, 1'b0};
        vecs[7]  = '{1'b1, 32'h24,  32'h12345678, 4'b0000, 32'h0,        1'b0};
        vecs[8]  = '{1'b0, 32'h24,  32'h0,        4'b0000, 32'h0,        1'b0};
        vecs[9]  = '{1'b1, 32'hFFC, 32'hCAFEF00D, 4'b1111, 32'h0,        1'b0};
        vecs[10] = '{1'b1, 32'h30,  32'h55667788, 4'b1010, 32'h0,        1'b0};
        vecs[11] = '{1'b0, 32'h30,  32'h0,        4'b0000, 32'h55007700, 1'b0};

        // Reset state and first clear
        repeat (2) @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        clr = 1'b0;
        count_busy("clear0_cycles");

        // Data written before a reset pulse is zeroed by the clear
        issue(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111);
        check_rsp("st10", 32'h0, 1'b0);
        issue(1'b0, 32'h10, 32'h0, 4'b0000);
        check_rsp("ld10", 32'hDEADBEEF, 1'b0);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        count_busy("clear1_cycles");
        issue(1'b0, 32'h10, 32'h0, 4'b0000);
        check_rsp("ld10_cleared", 32'h0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be);
            check_rsp($sformatf("vec%0d", i), vecs[i].exp_rdata, vecs[i].exp_err);
        end
        issue(1'b0, 32'hFFC, 32'h0, 4'b0000);
        check_rsp("ld_last_idx", 32'hCAFEF00D, 1'b0);

        // Back-pressure: response held for 5 cycles while another request waits
        @(negedge clk);
        rsp_ready = 1'b0;
        issue(1'b0, 32'h20, 32'h0, 4'b0000);
        check_rsp("bp_ld20", 32'h11BB33DD, 1'b0);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h40;
        req_wdata = 32'h00000099;
        req_be    = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("bp%0d_ready", i), 32'(req_ready), 32'd0);
            check_rsp($sformatf("bp%0d", i), 32'h11BB33DD, 1'b0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        check_rsp("bp_st40", 32'h0, 1'b0);
        issue(1'b0, 32'h40, 32'h0, 4'b0000);
        check_rsp("bp_ld40", 32'h00000099, 1'b0);

        // Back-to-back: one request per cycle, response checked the following cycle
        begin
            logic        bw [6];
            logic [31:0] ba [6];
            logic [31:0] bd [6];
            logic [31:0] be_exp [6];
            bw = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
            ba = '{32'h0, 32'h4, 32'h8, 32'h0, 32'h4, 32'h8};
            bd = '{32'h01010101, 32'h02020202, 32'h03030303, 32'h0, 32'h0, 32'h0};
            be_exp = '{32'h0, 32'h0, 32'h0, 32'h01010101, 32'h02020202, 32'h03030303};
            for (int i = 0; i <= 6; i++) begin
                if (i > 0) begin
                    check_rsp($sformatf("b2b%0d", i - 1), be_exp[i-1], 1'b0);
                end
                if (i < 6) begin
                    req_valid = 1'b1;
                    req_write = bw[i];
                    req_addr  = ba[i];
                    req_wdata = bd[i];
                    req_be    = 4'b1111;
                    #1;
                    chk($sformatf("b2b%0d_ready", i), 32'(req_ready), 32'd1);
                    @(negedge clk);
                end
            end
            req_valid = 1'b0;
        end

        // Reset in the middle of a clear restarts it from index 0
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        repeat (500) @(negedge clk);
        chk("midclear_busy", 32'(busy), 32'd1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        count_busy("clear_restart_cycles");

        // Reset while an errored response is pending drops it immediately
        rsp_ready = 1'b0;
        issue(1'b0, 32'h22, 32'h0, 4'b0000);
        check_rsp("pend_err", 32'h0, 1'b1);
        clr = 1'b1;
        #1;
        chk("clr_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("clr_rsp_err", 32'(rsp_err), 32'd0);
        chk("clr_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        clr = 1'b0;
        rsp_ready = 1'b1;
        count_busy("clear_after_rsp_cycles");
        chk("post_clear_valid", 32'(rsp_valid), 32'd0);
        issue(1'b0, 32'h20, 32'h0, 4'b0000);
        check_rsp("ld20_cleared", 32'h0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_ram.md
# data_ram

Parametrised single-port data memory for the RV core's load/store path. It adds byte-lane write strobes, a registered read port, a valid/ready request/response handshake with back-pressure, alignment and range checking, and a hardware clear sequencer that zeroes the whole array after reset. It sits between the core's memory stage and the word storage.

## Interface
- DATA_W, 32, word width in bits; multiple of 8, power of two.
- DEPTH, 1024, number of words; power of two, ≥ 2.
- ADDR_W, 32, byte-address width.
- CLEAR_ON_RESET, 1, 1 = zero the array after reset; 0 = skip the clear.
- clk  in  1  clock; all state changes on the rising edge.
- clr  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when high together with req_valid.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data.
- req_be  in  DATA_W/8  byte-lane write enables; ignored for loads.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  DATA_W  load data; 0 for stores and errors.
- rsp_err  out  1  misaligned or out-of-range request.
- busy  out  1  clear sequence in progress.

## Operation
- Derived values: BYTES = DATA_W/8, OFF_W = log2(BYTES), IDX_W = log2(DEPTH), idx = req_addr[OFF_W +: IDX_W].
- Error condition: any of req_addr[OFF_W-1:0] is nonzero, or any of req_addr[ADDR_W-1:OFF_W+IDX_W] is nonzero. An errored request does not touch the array. Its response has rsp_err = 1 and rsp_rdata = 0.
- FSM states:
  - CLEAR: busy = 1, req_ready = 0. A counter walks idx 0..DEPTH-1 and writes zero, one word per cycle. After the write to DEPTH-1 the FSM moves to RUN.
  - RUN: busy = 0.
- After reset the FSM enters CLEAR if CLEAR_ON_RESET = 1, otherwise RUN (array contents undefined).
- In RUN, req_ready = !rsp_valid || rsp_ready. This is combinational, so a new request can be accepted in the same cycle the held response is consumed.
- Accepted store: on the same edge, each byte lane b with req_be[b] = 1 is written; other lanes keep their value. req_be = 0 is legal and performs no write but still produces a response. The response has rsp_rdata = 0 and rsp_err = 0.
- Accepted load: rsp_rdata holds the word as it stood before the accepting edge.
- Response register: rsp_valid, rsp_rdata and rsp_err are loaded on accept. They hold stable while rsp_valid && !rsp_ready. rsp_valid clears when the response is consumed and no new request is accepted.
- clr asserted at any time: immediately drop any pending response and abort the clear. Then restart the clear from idx 0 after release. Stores in flight are lost.

## Timing
- Reset values: rsp_valid 0, rsp_rdata 0, rsp_err 0, req_ready 0, busy = CLEAR_ON_RESET, clear counter 0.
- Clear sequence (CLEAR_ON_RESET = 1): clear edge k (k = 1..DEPTH after clr release) writes idx k-1. Following edge DEPTH, busy = 0 and req_ready = 1.
- Latency: request accepted at edge n gives rsp_valid = 1 after edge n. Throughput is one request per cycle while rsp_ready = 1.
- Store accepted at edge n followed by a load of the same idx accepted at edge n+1 returns the stored data.
- Back-pressure: while rsp_ready = 0 and rsp_valid = 1, req_ready = 0 and all rsp_* outputs are stable.

## Structure
- Shared package mem_pkg holds:
  - the state enum (CLEAR, RUN);
  - a clog2 helper;
  - an error-check function taking addr, OFF_W and IDX_W.
- Sub-module data_ram_array: DEPTH × DATA_W storage with byte-enabled write port and registered read port. It has no reset, which keeps it inferable as block RAM.
- The FSM, clear counter, handshake and response register live in data_ram.

## Test plan
- Reset clear: write 0xDEADBEEF to addr 0x10, pulse clr. Expect busy high for exactly DEPTH cycles. A later load of 0x10 returns 0x00000000.
- Byte strobes: store 0x11223344 at 0x20 with be = 4'b1111, then 0xAABBCCDD with be = 4'b0101. Load returns 0x11BB33DD.
- Errors: load 0x22 (misaligned) and load 0x1000 (DEPTH = 1024, out of range). Both give rsp_err = 1 and rdata 0. Array contents are unchanged.
- Back-pressure: hold rsp_ready = 0 for 5 cycles after a load of 0x20. rsp_* stay stable and req_ready = 0. On release, a new request is accepted that cycle.
- Back-to-back: stores to 0x0, 0x4, 0x8 in 3 consecutive cycles, then loads of the same addresses in the next 3 cycles, all with rsp_ready = 1. Expect one response per cycle with correct data.
- Reset mid-clear and mid-response: assert clr at clear idx 500 and while a response is pending. Expect rsp_valid = 0 immediately and the clear restarts at idx 0.
